// File: rtl/shake_input_buffer_if.sv
`default_nettype none
// ============================================================================
// shake_input_buffer_if : load-side and absorb-side signals of the SHAKE
// rate buffer. Revision 1.0
// ============================================================================
interface shake_input_buffer_if #(
  parameter int MAX_RATE_WORDS = 21,
  parameter int W              = 64
);
  logic                        mode_i;
  logic                        load_enable;
  logic [W-1:0]                data_i;
  logic                        last_word_i;
  logic [3:0]                  last_bytes_i;
  logic                        block_ready_i;
  logic                        block_valid_o;
  logic [MAX_RATE_WORDS*W-1:0] block_o;
  logic                        block_last_o;
  logic                        buffer_empty_o;
  logic                        buffer_full_o;

  modport slave (
    input  mode_i, load_enable, data_i, last_word_i, last_bytes_i, block_ready_i,
    output block_valid_o, block_o, block_last_o, buffer_empty_o, buffer_full_o
  );

  modport master (
    output mode_i, load_enable, data_i, last_word_i, last_bytes_i, block_ready_i,
    input  block_valid_o, block_o, block_last_o, buffer_empty_o, buffer_full_o
  );
endinterface
`default_nettype wire

// File: rtl/shake_input_buffer.sv
`default_nettype none
// ============================================================================
// shake_input_buffer : collects 64-bit words into a SHAKE rate block and pads
// it (0x1F .. 0x80). Optional SHAKE_INPUT_BUFFER_ZEROIZE_EN clears storage on
// every transfer. Revision 1.0
// ============================================================================
module shake_input_buffer #(
  parameter int MAX_RATE_WORDS = 21,
  parameter int W              = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  shake_input_buffer_if.slave bus
);
  localparam int CW = $clog2(MAX_RATE_WORDS + 1);
  localparam int NB = MAX_RATE_WORDS * W / 8;
  localparam logic [CW-1:0] RATE_128 = CW'(21);
  localparam logic [CW-1:0] RATE_256 = CW'(17);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {S_EMPTY, S_FILL, S_PAD, S_FULL} state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               count_q, count_d;
  logic [CW-1:0]               rate_q, rate_d;
  logic [CW-1:0]               pad_word_q, pad_word_d;
  logic [2:0]                  pad_byte_q, pad_byte_d;
  logic                        pad_pending_q, pad_pending_d;
  logic                        last_q, last_d;
  logic [MAX_RATE_WORDS*W-1:0] block_q, block_d;

  logic [CW-1:0] idx;
  logic [CW-1:0] rate_eff;
  logic [CW-1:0] last_pad_word;
  logic          full_word;
  logic [CW+2:0] pad_pos;
  int            last_pos;

  assign pad_pos = {pad_word_q, pad_byte_q};

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rate_d        = rate_q;
    pad_word_d    = pad_word_q;
    pad_byte_d    = pad_byte_q;
    pad_pending_d = pad_pending_q;
    last_d        = last_q;
    block_d       = block_q;
    // The rate is taken from mode_i only on the first word of a message.
    rate_eff      = (state_q == S_EMPTY) ? (bus.mode_i ? RATE_256 : RATE_128) : rate_q;
    idx           = (state_q == S_EMPTY) ? '0 : count_q;
    // Byte counts above 8 are treated as a full word.
    full_word     = (bus.last_bytes_i >= 4'd8);
    last_pad_word = full_word ? (idx + ONE) : idx;
    last_pos      = int'(rate_q) * 8 - 1;

    case (state_q)
      S_EMPTY, S_FILL: begin
        if (bus.load_enable) begin
          rate_d                      = rate_eff;
          block_d[int'(idx)*W +: W]   = bus.data_i;
          if (bus.last_word_i) begin
            pad_word_d = last_pad_word;
            pad_byte_d = bus.last_bytes_i[2:0] & {3{~full_word}};
            count_d    = '0;
            if (last_pad_word < rate_eff) begin
              state_d = S_PAD;
            end else begin
              // Message ends exactly on the rate boundary: padding goes in a second block.
              state_d       = S_FULL;
              pad_pending_d = 1'b1;
              last_d        = 1'b0;
            end
          end else if (idx == rate_eff - ONE) begin
            state_d = S_FULL;
            last_d  = 1'b0;
            count_d = '0;
          end else begin
            state_d = S_FILL;
            count_d = idx + ONE;
          end
        end
      end

      S_PAD: begin
        for (int p = 0; p < NB; p++) begin
          if (p == int'(pad_pos)) begin
            block_d[p*8 +: 8] = 8'h1F;
          end else if (p > int'(pad_pos)) begin
            block_d[p*8 +: 8] = 8'h00;
          end
          if (p == last_pos) begin
            block_d[p*8 +: 8] = block_d[p*8 +: 8] | 8'h80;
          end
        end
        last_d  = 1'b1;
        state_d = S_FULL;
      end

      S_FULL: begin
        if (bus.block_ready_i) begin
          last_d = 1'b0;
          if (pad_pending_q) begin
            block_d       = '0;
            pad_pending_d = 1'b0;
            pad_word_d    = '0;
            pad_byte_d    = '0;
            state_d       = S_PAD;
          end else begin
            state_d = S_EMPTY;
            count_d = '0;
`ifdef SHAKE_INPUT_BUFFER_ZEROIZE_EN
            block_d = '0;
`else
            block_d = block_q;
`endif
          end
        end
      end

      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_EMPTY;
      count_q       <= '0;
      rate_q        <= RATE_128;
      pad_word_q    <= '0;
      pad_byte_q    <= '0;
      pad_pending_q <= 1'b0;
      last_q        <= 1'b0;
      block_q       <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rate_q        <= rate_d;
      pad_word_q    <= pad_word_d;
      pad_byte_q    <= pad_byte_d;
      pad_pending_q <= pad_pending_d;
      last_q        <= last_d;
      block_q       <= block_d;
    end
  end

  assign bus.block_valid_o  = (state_q == S_FULL);
  assign bus.buffer_full_o  = (state_q == S_FULL);
  assign bus.block_last_o   = (state_q == S_FULL) && last_q;
  assign bus.buffer_empty_o = (state_q == S_EMPTY);

  // Words beyond the active rate may hold stale data; they never leave the block.
  for (genvar j = 0; j < MAX_RATE_WORDS; j++) begin : g_mask
    assign bus.block_o[j*W +: W] = (CW'(j) < rate_q) ? block_q[j*W +: W] : '0;
  end
endmodule
`default_nettype wire

// File: tb/tb_shake_input_buffer.sv
`default_nettype none
// tb_shake_input_buffer : table of messages scored against a padding model,
// plus hand sequences for back-pressure, padding corners and async reset.
module tb_shake_input_buffer;
  localparam int MRW = 21;
  localparam int BW  = MRW * 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shake_input_buffer_if #(.MAX_RATE_WORDS(MRW), .W(64)) bus ();

  shake_input_buffer #(.MAX_RATE_WORDS(MRW), .W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       mode;
    int         nwords;
    logic       has_last;
    logic [3:0] nb;
    logic       rnd;
    int         exp_blocks;
  } vec_t;

  typedef struct {
    logic [BW-1:0] data;
    logic          last;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks   = 0;
  int          n_fail     = 0;
  int          xfer_count = 0;
  logic        hold       = 1'b1;
  logic [63:0] msg_w [64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_block(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      for (int j = 0; j < MRW; j++) begin
        if (act[j*64 +: 64] !== exp[j*64 +: 64]) begin
          $display("FAIL %s: word %0d got %h expected %h", name, j, act[j*64 +: 64], exp[j*64 +: 64]);
          break;
        end
      end
    end
  endtask

  // Reference padding: M || 0x1F || 0* || 0x80 up to a multiple of the rate.
  task automatic push_expected(input logic mode, input int nwords, input logic has_last, input logic [3:0] nb);
    logic [7:0] pb [512];
    int         r, len, total, nblk;
    exp_t       e;
    r   = mode ? 136 : 168;
    len = has_last ? (nwords - 1) * 8 + int'(nb) : nwords * 8;
    for (int p = 0; p < 512; p++) pb[p] = (p < len) ? msg_w[p/8][(p%8)*8 +: 8] : 8'h00;
    if (has_last) begin
      pb[len]       = 8'h1F;
      total         = ((len + r) / r) * r;
      pb[total - 1] = pb[total - 1] | 8'h80;
    end else begin
      total = len;
    end
    nblk = total / r;
    for (int k = 0; k < nblk; k++) begin
      e.data = '0;
      for (int p = 0; p < r; p++) e.data[p*8 +: 8] = pb[k*r + p];
      e.last = has_last && (k == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  // Absorb side: random ready, compare each transferred block with the scoreboard.
  initial begin
    exp_t e;
    bus.block_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.block_ready_i = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (rst_n && bus.block_valid_o && bus.block_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_block: got a valid block, expected none");
        end else begin
          e = exp_q.pop_front();
          chk_block("block_data", bus.block_o, e.data);
          chk("block_last", 64'(bus.block_last_o), 64'(e.last));
          chk("buffer_full", 64'(bus.buffer_full_o), 64'd1);
        end
        xfer_count++;
      end
    end
  end

  task automatic wait_empty(input string name);
    int n = 0;
    while (!bus.buffer_empty_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!bus.buffer_empty_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got buffer_empty_o=0 after 400 cycles, expected 1", name);
    end
  endtask

  task automatic write_word(input logic mode, input logic [63:0] d, input logic last, input logic [3:0] nb);
    bus.mode_i       = mode;
    bus.data_i       = d;
    bus.last_word_i  = last;
    bus.last_bytes_i = nb;
    bus.load_enable  = 1'b1;
    @(negedge clk);
    bus.load_enable  = 1'b0;
    bus.last_word_i  = 1'b0;
    bus.last_bytes_i = 4'd0;
  endtask

  task automatic run_msg(input vec_t v, input int id);
    int   rw, in_blk, start, pw;
    logic is_last;
    rw = v.mode ? 17 : 21;
    wait_empty("pre_msg");
    for (int k = 0; k < v.nwords; k++) msg_w[k] = v.rnd ? {$urandom, $urandom} : {8{8'(k + 1)}};
    push_expected(v.mode, v.nwords, v.has_last, v.nb);
    start  = xfer_count;
    in_blk = 0;
    for (int k = 0; k < v.nwords; k++) begin
      is_last = v.has_last && (k == v.nwords - 1);
      write_word(v.mode, msg_w[k], is_last, v.nb);
      in_blk++;
      if (is_last) begin
        pw = (v.nb >= 4'd8) ? in_blk : in_blk - 1;
        if (pw < rw) begin
          chk("latency_pad_gap", 64'(bus.block_valid_o), 64'd0);
          @(negedge clk);
        end
        chk("latency_valid", 64'(bus.block_valid_o), 64'd1);
        chk("last_at_valid", 64'(bus.block_last_o), 64'(pw < rw));
      end else if (in_blk == rw) begin
        chk("latency_valid_full", 64'(bus.block_valid_o), 64'd1);
        chk("last_at_valid_full", 64'(bus.block_last_o), 64'd0);
        wait_empty("block_done");
        in_blk = 0;
      end
    end
    wait_empty("msg_done");
    chk($sformatf("blocks_msg%0d", id), 64'(xfer_count - start), 64'(v.exp_blocks));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no summary by time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [10];
    vec_t solo;
    int   n;
    tbl[0] = '{1'b0, 21, 1'b0, 4'd0, 1'b0, 1};
    tbl[1] = '{1'b0,  1, 1'b1, 4'd0, 1'b0, 1};
    tbl[2] = '{1'b1,  3, 1'b1, 4'd3, 1'b1, 1};
    tbl[3] = '{1'b1, 17, 1'b1, 4'd8, 1'b0, 2};
    tbl[4] = '{1'b0, 21, 1'b1, 4'd7, 1'b0, 1};
    tbl[5] = '{1'b0,  5, 1'b1, 4'd8, 1'b1, 1};
    tbl[6] = '{1'b1, 17, 1'b1, 4'd5, 1'b1, 1};
    tbl[7] = '{1'b0, 21, 1'b1, 4'd8, 1'b1, 2};
    tbl[8] = '{1'b1, 16, 1'b1, 4'd8, 1'b0, 1};
    tbl[9] = '{1'b1, 25, 1'b1, 4'd4, 1'b1, 2};

    bus.mode_i       = 1'b0;
    bus.load_enable  = 1'b0;
    bus.data_i       = '0;
    bus.last_word_i  = 1'b0;
    bus.last_bytes_i = 4'd0;

    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(bus.block_valid_o), 64'd0);
    chk("rst_full", 64'(bus.buffer_full_o), 64'd0);
    chk("rst_last", 64'(bus.block_last_o), 64'd0);
    chk("rst_empty", 64'(bus.buffer_empty_o), 64'd1);
    chk_block("rst_block", bus.block_o, '0);
    rst_n = 1'b1;
    hold  = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_msg(tbl[i], i);

    // SHAKE256 partial last word held under back-pressure with load_enable pulsing.
    wait_empty("hand_pre");
    hold     = 1'b1;
    msg_w[0] = 64'h0123456789ABCDEF;
    msg_w[1] = 64'h1111111111111111;
    msg_w[2] = 64'hAABBCCDDEEFF1122;
    push_expected(1'b1, 3, 1'b1, 4'd3);
    write_word(1'b1, msg_w[0], 1'b0, 4'd0);
    write_word(1'b1, msg_w[1], 1'b0, 4'd0);
    write_word(1'b1, msg_w[2], 1'b1, 4'd3);
    n = 0;
    while (!bus.block_valid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("hand_valid", 64'(bus.block_valid_o), 64'd1);
    chk("hand_word2", bus.block_o[2*64 +: 64], 64'h000000001FFF1122);
    chk("hand_word16", bus.block_o[16*64 +: 64], 64'h8000000000000000);
    for (int j = 17; j < MRW; j++) chk($sformatf("hand_tail_w%0d", j), bus.block_o[j*64 +: 64], 64'd0);
    chk("hand_last", 64'(bus.block_last_o), 64'd1);
    for (int c = 0; c < 10; c++) begin
      bus.load_enable = c[0];
      bus.data_i      = {$urandom, $urandom};
      @(negedge clk);
      chk_block("hold_block", bus.block_o, exp_q[0].data);
      chk("hold_valid", 64'(bus.block_valid_o), 64'd1);
      chk("hold_empty", 64'(bus.buffer_empty_o), 64'd0);
    end
    bus.load_enable = 1'b0;
    hold = 1'b0;
    wait_empty("hand_done");
    chk("hand_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset in the middle of a fill discards the partial block.
    hold = 1'b1;
    for (int k = 0; k < 5; k++) write_word(1'b1, {$urandom, $urandom}, 1'b0, 4'd0);
    chk("fill_not_empty", 64'(bus.buffer_empty_o), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.block_valid_o), 64'd0);
    chk("arst_full", 64'(bus.buffer_full_o), 64'd0);
    chk("arst_last", 64'(bus.block_last_o), 64'd0);
    chk("arst_empty", 64'(bus.buffer_empty_o), 64'd1);
    chk_block("arst_block", bus.block_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    hold  = 1'b0;
    solo  = '{1'b0, 1, 1'b1, 4'd0, 1'b0, 1};
    run_msg(solo, 10);
    solo  = '{1'b0, 21, 1'b1, 4'd3, 1'b1, 1};
    run_msg(solo, 11);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
